ca_step_controller: RTL and testbench

CA_STEP_CONTROLLER -- requirements
Module: ca_step_controller

---
 rtl/ca_ctrl_pkg.sv | 23 ++
 rtl/ca_step_timer.sv | 35 +++
 rtl/ca_step_controller.sv | 160 ++++++++++++++++
 tb/tb_ca_step_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_ctrl_pkg.sv
// Shared definitions for the cellular-automaton step controller:
// controller states, settle length and default parameter values.
package ca_ctrl_pkg;

    localparam int DEF_N_CELLS   = 64;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_DIV_W     = 16;
    localparam int DEF_GEN_W     = 16;

    // Cycles spent with load=1 after the last pattern write, covering the
    // cell adder and the output-sync register before the first generation.
    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        PAUSE,
        DONE
    } ca_state_t;

endpackage

// File: rtl/ca_step_timer.sv
// Generation period counter. Loaded with (period-1), counts down while
// enabled and reloads itself after reaching zero; tc flags the zero count.
module ca_step_timer
    import ca_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_value,
    input  logic             enable,
    output logic             tc
);

    logic [DIV_W-1:0] count;

    // Down-counter: explicit load wins, otherwise count/reload while enabled, hold when disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            if (count == '0) begin
                count <= load_value;
            end else begin
                count <= count - DIV_W'(1);
            end
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ca_step_controller.sv
// Step controller for a cellular-automaton grid: loads an initial pattern
// into the cells, lets the cell pipeline settle, then issues time_step
// pulses at a programmable period until an optional generation limit.
// Optional feature macro: CA_CTRL_SINGLE_STEP_EN enables single_step
// generation advances while paused; without it single_step is ignored.
module ca_step_controller
    import ca_ctrl_pkg::*;
#(
    parameter int N_CELLS = DEF_N_CELLS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int GEN_W   = DEF_GEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              single_step,
    input  logic [DIV_W-1:0]  step_period,
    input  logic [GEN_W-1:0]  gen_limit,
    input  logic              pat_valid,
    input  logic [1:0]        pat_data,
    output logic              pat_ready,
    output logic              load,
    output logic [1:0]        load_val,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_we,
    output logic              time_step,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_CELLS - 1);
    localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    ca_state_t          state;
    logic [ADDR_W-1:0]  beat_idx;
    logic [1:0]         settle_cnt;
    logic [DIV_W-1:0]   period_reload;
    logic               timer_load;
    logic               timer_en;
    logic               timer_tc;
    logic               beat;
    logic               step_req;
    logic [GEN_W-1:0]   gen_next;
    logic               hit_limit;

    // A period of 0 behaves like 1, so the reload value saturates at zero.
    assign period_reload = (step_period == '0) ? '0 : (step_period - DIV_W'(1));
    assign timer_load    = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    assign timer_en      = (state == RUN);
    assign beat          = (state == LOAD) && pat_valid;
    assign gen_next      = gen_count + GEN_W'(1);
    assign hit_limit     = (gen_limit != '0) && (gen_next == gen_limit);

`ifdef CA_CTRL_SINGLE_STEP_EN
    // Suppressed right after a pulse so time_step never fires back to back in PAUSE.
    assign step_req = single_step && !time_step;
`else
    assign step_req = single_step & 1'b0;
`endif

    ca_step_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (period_reload),
        .enable     (timer_en),
        .tc         (timer_tc)
    );

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_idx   <= '0;
            settle_cnt <= '0;
            pat_ready  <= 1'b0;
            load       <= 1'b0;
            load_val   <= '0;
            load_addr  <= '0;
            load_we    <= 1'b0;
            time_step  <= 1'b0;
            gen_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_we   <= 1'b0;
            time_step <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        beat_idx  <= '0;
                        load_addr <= '0;
                        gen_count <= '0;
                        pat_ready <= 1'b1;
                        load      <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        load_we   <= 1'b1;
                        load_addr <= beat_idx;
                        load_val  <= pat_data;
                        beat_idx  <= beat_idx + ADDR_W'(1);
                        if (beat_idx == LAST_ADDR) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                            pat_ready  <= 1'b0;
                            load       <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                RUN: begin
                    if (timer_tc) begin
                        time_step <= 1'b1;
                        gen_count <= gen_next;
                    end
                    if (timer_tc && hit_limit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (pause) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state <= RUN;
                    end else if (step_req) begin
                        time_step <= 1'b1;
                        gen_count <= gen_next;
                        if (hit_limit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ca_step_controller.sv
// Directed bench for ca_step_controller with a 4-cell grid and 4-bit
// generation counter. Expected values are hand-derived cycle positions.
module tb_ca_step_controller;

`ifdef CA_CTRL_SINGLE_STEP_EN
    localparam int STEP_EN = 1;
`else
    localparam int STEP_EN = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       single_step = 1'b0;
    logic [7:0] step_period = 8'd3;
    logic [3:0] gen_limit = 4'd5;
    logic       pat_valid = 1'b0;
    logic [1:0] pat_data = 2'd0;
    logic       pat_ready;
    logic       load;
    logic [1:0] load_val;
    logic [1:0] load_addr;
    logic       load_we;
    logic       time_step;
    logic [3:0] gen_count;
    logic       busy;
    logic       done;

    int totalChecks = 0;
    int badChecks = 0;

    bit       bpValid [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit       bpStart [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit [1:0] bpData  [8] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2};
    bit [1:0] aData   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    ca_step_controller #(
        .N_CELLS(4),
        .ADDR_W (2),
        .DIV_W  (8),
        .GEN_W  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .single_step (single_step),
        .step_period (step_period),
        .gen_limit   (gen_limit),
        .pat_valid   (pat_valid),
        .pat_data    (pat_data),
        .pat_ready   (pat_ready),
        .load        (load),
        .load_val    (load_val),
        .load_addr   (load_addr),
        .load_we     (load_we),
        .time_step   (time_step),
        .gen_count   (gen_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock them in, and settle 1ns past the edge.
    task automatic applyStimulus(input logic s, input logic p, input logic ss,
                                 input logic v, input logic [1:0] d);
        start       = s;
        pause       = p;
        single_step = ss;
        pat_valid   = v;
        pat_data    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ready"}, 32'(pat_ready), 32'd0);
        checkOutput({tag, ".load"},  32'(load),      32'd0);
        checkOutput({tag, ".val"},   32'(load_val),  32'd0);
        checkOutput({tag, ".addr"},  32'(load_addr), 32'd0);
        checkOutput({tag, ".we"},    32'(load_we),   32'd0);
        checkOutput({tag, ".ts"},    32'(time_step), 32'd0);
        checkOutput({tag, ".gen"},   32'(gen_count), 32'd0);
        checkOutput({tag, ".busy"},  32'(busy),      32'd0);
        checkOutput({tag, ".done"},  32'(done),      32'd0);
    endtask

    initial begin
        int k;
        int expGen;

        // Power-on reset
        repeat (2) @(posedge clock);
        #1;
        checkResetState("por");
        reset = 1'b0;

        // Continuous load, then period 3 with a limit of 5 generations
        step_period = 8'd3;
        gen_limit   = 4'd5;
        applyStimulus(1, 0, 0, 0, 2'd0);
        checkOutput("a.ready", 32'(pat_ready), 32'd1);
        checkOutput("a.busy",  32'(busy),      32'd1);
        checkOutput("a.load",  32'(load),      32'd0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(0, 0, 0, 1, aData[b]);
            checkOutput("a.we",    32'(load_we),   32'd1);
            checkOutput("a.addr",  32'(load_addr), 32'(b));
            checkOutput("a.val",   32'(load_val),  32'(aData[b]));
            checkOutput("a.ready", 32'(pat_ready), (b < 3) ? 32'd1 : 32'd0);
            checkOutput("a.load",  32'(load),      (b < 3) ? 32'd0 : 32'd1);
        end
        // Pulses expected 5,8,11,14,17 cycles after the last beat
        for (int i = 1; i <= 22; i++) begin
            applyStimulus(0, 0, 0, 0, 2'd0);
            expGen = (i < 5) ? 0 : (((i - 5) / 3 + 1) > 5 ? 5 : ((i - 5) / 3 + 1));
            checkOutput("a.ts",   32'(time_step),
                        (i >= 5 && i <= 17 && ((i - 5) % 3) == 0) ? 32'd1 : 32'd0);
            checkOutput("a.gen",  32'(gen_count), 32'(expGen));
            checkOutput("a.done", 32'(done), (i >= 17) ? 32'd1 : 32'd0);
            checkOutput("a.busy", 32'(busy), (i >= 17) ? 32'd0 : 32'd1);
            if (i == 1) checkOutput("a.weoff", 32'(load_we), 32'd0);
        end

        // Restart from DONE, load with gaps in pat_valid; start in LOAD is ignored
        step_period = 8'd4;
        gen_limit   = 4'd0;
        applyStimulus(1, 0, 0, 0, 2'd0);
        checkOutput("b.gen",   32'(gen_count), 32'd0);
        checkOutput("b.done",  32'(done),      32'd0);
        checkOutput("b.ready", 32'(pat_ready), 32'd1);
        checkOutput("b.addr",  32'(load_addr), 32'd0);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(bpStart[i], 0, 0, bpValid[i], bpData[i]);
            checkOutput("bp.we", 32'(load_we), 32'(bpValid[i]));
            if (bpValid[i]) begin
                checkOutput("bp.addr", 32'(load_addr), 32'(k));
                checkOutput("bp.val",  32'(load_val),  32'(bpData[i]));
                k++;
            end
            checkOutput("bp.ready", 32'(pat_ready), (k < 4) ? 32'd1 : 32'd0);
            checkOutput("bp.load",  32'(load),      (k < 4) ? 32'd0 : 32'd1);
        end

        // Period 4: pulses at 6 and 10; single_step in RUN (8) and with pause rise (11) ignored
        for (int j = 1; j <= 11; j++) begin
            applyStimulus(0, (j == 11), (j == 8 || j == 11), 0, 2'd0);
            checkOutput("p.ts", 32'(time_step), (j == 6 || j == 10) ? 32'd1 : 32'd0);
            checkOutput("p.gen", 32'(gen_count), (j >= 10) ? 32'd2 : ((j >= 6) ? 32'd1 : 32'd0));
        end
        checkOutput("p.busy", 32'(busy), 32'd1);

        // Two single steps while paused
        applyStimulus(0, 1, 1, 0, 2'd0);
        checkOutput("s1.ts",  32'(time_step), 32'(STEP_EN));
        checkOutput("s1.gen", 32'(gen_count), 32'(2 + STEP_EN));
        applyStimulus(0, 1, 0, 0, 2'd0);
        checkOutput("s1.off", 32'(time_step), 32'd0);
        applyStimulus(0, 1, 1, 0, 2'd0);
        checkOutput("s2.ts",  32'(time_step), 32'(STEP_EN));
        checkOutput("s2.gen", 32'(gen_count), 32'(2 + 2 * STEP_EN));
        applyStimulus(0, 1, 0, 0, 2'd0);
        checkOutput("s2.off", 32'(time_step), 32'd0);
        checkOutput("s2.hold", 32'(gen_count), 32'(2 + 2 * STEP_EN));

        // Release: counter resumes at 2, so the pulse lands on the 4th cycle
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(0, 0, 0, 0, 2'd0);
            checkOutput("r.ts", 32'(time_step), (j == 4) ? 32'd1 : 32'd0);
        end
        checkOutput("r.gen", 32'(gen_count), 32'(3 + 2 * STEP_EN));

        // start while running has no effect
        applyStimulus(1, 0, 0, 0, 2'd0);
        checkOutput("rs.ready", 32'(pat_ready), 32'd0);
        checkOutput("rs.busy",  32'(busy),      32'd1);
        checkOutput("rs.load",  32'(load),      32'd1);
        checkOutput("rs.gen",   32'(gen_count), 32'(3 + 2 * STEP_EN));
        start = 1'b0;

        // Asynchronous reset mid-RUN, between clock edges
        #2 reset = 1'b1;
        #1 checkResetState("rstRun");
        @(posedge clock);
        #1 reset = 1'b0;

        // step_period=0: a pulse every RUN cycle, 4-bit gen_count wraps
        step_period = 8'd0;
        gen_limit   = 4'd0;
        applyStimulus(1, 0, 0, 0, 2'd0);
        checkOutput("c.ready", 32'(pat_ready), 32'd1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(0, 0, 0, 1, 2'd3);
        end
        checkOutput("c.addr", 32'(load_addr), 32'd3);
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(0, 0, 0, 0, 2'd0);
            checkOutput("c.ts",  32'(time_step), (j >= 3) ? 32'd1 : 32'd0);
            checkOutput("c.gen", 32'(gen_count), (j >= 3) ? 32'((j - 2) % 16) : 32'd0);
            if (j == 17) checkOutput("c.top",  32'(gen_count), 32'd15);
            if (j == 18) checkOutput("c.wrap", 32'(gen_count), 32'd0);
        end

        // Reset mid-LOAD at address 2, then restart from address 0
        #2 reset = 1'b1;
        #1;
        @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(1, 0, 0, 0, 2'd0);
        for (int b = 1; b <= 3; b++) begin
            applyStimulus(0, 0, 0, 1, 2'(b));
        end
        checkOutput("d.addr", 32'(load_addr), 32'd2);
        checkOutput("d.we",   32'(load_we),   32'd1);
        #2 reset = 1'b1;
        #1 checkResetState("rstLoad");
        @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(1, 0, 0, 0, 2'd0);
        checkOutput("d2.ready", 32'(pat_ready), 32'd1);
        checkOutput("d2.busy",  32'(busy),      32'd1);
        applyStimulus(0, 0, 0, 1, 2'd2);
        checkOutput("d2.we",   32'(load_we),   32'd1);
        checkOutput("d2.addr", 32'(load_addr), 32'd0);
        checkOutput("d2.val",  32'(load_val),  32'd2);
        applyStimulus(0, 0, 0, 1, 2'd1);
        checkOutput("d2.addr1", 32'(load_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
